// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
//   Shared widths and FSM state type for the instruction cache.
//   ADDR_WIDTH / ID_WIDTH: fetch address and instruction word widths.
//   ICACHE_INDEX_WIDTH   : default log2(number of lines).
// ---------------------------------------------------------------------------
package icache_pkg;

   localparam int ADDR_WIDTH         = 32;
   localparam int ID_WIDTH           = 32;
   localparam int ICACHE_INDEX_WIDTH = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MISS = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// icache_array
//   Valid/tag/data storage for the direct-mapped instruction cache.
//   Valid bits are cleared by the asynchronous reset; tag and data are not.
//   Ports:
//     clk_in, rst_in   clock, asynchronous active-low reset
//     rd_idx           combinational read index
//     rd_valid/tag/data  line contents at rd_idx
//     we, wr_idx, wr_tag, wr_data  synchronous line fill
// ---------------------------------------------------------------------------
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
   parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [INDEX_WIDTH-1:0] rd_idx,
   output logic                   rd_valid,
   output logic [TAG_WIDTH-1:0]   rd_tag,
   output logic [ID_WIDTH-1:0]    rd_data,
   input  logic                   we,
   input  logic [INDEX_WIDTH-1:0] wr_idx,
   input  logic [TAG_WIDTH-1:0]   wr_tag,
   input  logic [ID_WIDTH-1:0]    wr_data
);

   localparam int LINES = 1 << INDEX_WIDTH;

   logic [LINES-1:0]     valid_q;
   logic [TAG_WIDTH-1:0] tag_q  [LINES];
   logic [ID_WIDTH-1:0]  data_q [LINES];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (we) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
//   Direct-mapped read-only instruction cache, one 32-bit word per line.
//   Hits answer one cycle after acceptance; misses refill one word through
//   the ram_controller instruction port, fill the line, then answer.
//   Ports:
//     clk_in, rst_in      clock, asynchronous active-low reset
//     rdy_in              global ready, low freezes all state and outputs
//     clear_in            mispredict: abandon the pending fetch
//     fetch_en_in/addr_in fetcher request, held until fetch_rdy_out
//     fetch_rdy_out       one-cycle pulse, fetch_inst_out valid
//     fetch_inst_out      instruction word
//     mem_en_out/addr_out refill request, held until mem_rdy_in
//     mem_rdy_in/inst_in  refill response pulse and word
// ---------------------------------------------------------------------------
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clear_in,
   input  logic                  fetch_en_in,
   input  logic [ADDR_WIDTH-1:0] fetch_addr_in,
   output logic                  fetch_rdy_out,
   output logic [ID_WIDTH-1:0]   fetch_inst_out,
   output logic                  mem_en_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   input  logic                  mem_rdy_in,
   input  logic [ID_WIDTH-1:0]   mem_inst_in
);

   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

   icache_state_t         state, state_d;
   logic                  discard, discard_d;
   logic                  fetch_rdy_d;
   logic [ID_WIDTH-1:0]   fetch_inst_d;
   logic                  mem_en_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;

   logic [INDEX_WIDTH-1:0] fetch_idx;
   logic [TAG_WIDTH-1:0]   fetch_tag;
   logic                   line_valid;
   logic [TAG_WIDTH-1:0]   line_tag;
   logic [ID_WIDTH-1:0]    line_data;
   logic                   hit;
   logic                   fill_we;
   logic                   unused_addr_lsb;

   assign fetch_idx       = fetch_addr_in[INDEX_WIDTH+1:2];
   assign fetch_tag       = fetch_addr_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign unused_addr_lsb = ^fetch_addr_in[1:0];
   assign hit             = line_valid && (line_tag == fetch_tag);

   // The fill happens even when the fetch was cleared: the returned word is
   // still correct for mem_addr_out, so caching it is free.
   assign fill_we = rdy_in && (state == ST_MISS) && mem_rdy_in;

   icache_array #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH)
   ) u_array (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rd_idx   (fetch_idx),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .we       (fill_we),
      .wr_idx   (mem_addr_out[INDEX_WIDTH+1:2]),
      .wr_tag   (mem_addr_out[ADDR_WIDTH-1:INDEX_WIDTH+2]),
      .wr_data  (mem_inst_in)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= ST_IDLE;
         discard        <= 1'b0;
         fetch_rdy_out  <= 1'b0;
         fetch_inst_out <= '0;
         mem_en_out     <= 1'b0;
         mem_addr_out   <= '0;
      end else if (rdy_in) begin
         state          <= state_d;
         discard        <= discard_d;
         fetch_rdy_out  <= fetch_rdy_d;
         fetch_inst_out <= fetch_inst_d;
         mem_en_out     <= mem_en_d;
         mem_addr_out   <= mem_addr_d;
      end
   end

   always_comb begin
      state_d      = state;
      discard_d    = discard;
      fetch_rdy_d  = 1'b0;
      fetch_inst_d = fetch_inst_out;
      mem_en_d     = mem_en_out;
      mem_addr_d   = mem_addr_out;

      unique case (state)
         ST_IDLE: begin
            // fetch_rdy_out high means the fetcher is still presenting the
            // address just answered; accepting it again would double-answer.
            if (!clear_in && fetch_en_in && !fetch_rdy_out) begin
               if (hit) begin
                  fetch_rdy_d  = 1'b1;
                  fetch_inst_d = line_data;
               end else begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = fetch_addr_in;
                  state_d    = ST_MISS;
               end
            end
         end
         ST_MISS: begin
            // The refill cannot be aborted, so a clear only suppresses the answer.
            if (clear_in) begin
               discard_d = 1'b1;
            end
            if (mem_rdy_in) begin
               mem_en_d = 1'b0;
               if (!discard && !clear_in) begin
                  fetch_rdy_d  = 1'b1;
                  fetch_inst_d = mem_inst_in;
               end
               discard_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
